key_conditioner: RTL and testbench

//   Input-conditioning stage directly upstream of the stopwatch core on DE10-Lite.

---
 rtl/key_cond_pkg.sv | 19 +
 rtl/key_debounce_ch.sv | 150 +++++++++++++++
 rtl/key_conditioner.sv | 47 ++++
 tb/tb_key_conditioner.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/key_cond_pkg.sv
// key_cond_pkg
//   Shared definitions for the push-button conditioning slice:
//   - key_state_t : per-key debounce FSM states
//   - cnt_width() : width of the debounce and long-press counters. It is sized
//                   to hold LONG_CYCLES so that the long counter can saturate.
package key_cond_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_state_t;

  function automatic int cnt_width(input int long_cycles);
    return $clog2(long_cycles + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch
//   One push-button channel. It synchronises the raw active-low key, debounces
//   it and produces a clean level plus single-cycle press/release pulses. It
//   also produces a long-press pulse when KEY_LONGPRESS_EN is defined.
// Configuration
//   KEY_LONGPRESS_EN : when defined, long_pulse fires once LONG_CYCLES cycles
//                      after press_pulse while the key stays committed-down.
//                      When undefined, long_pulse is tied to 0.
// Ports
//   clk           in   system clock
//   rst           in   asynchronous reset, active-high
//   key_n         in   raw button, active-low (0 = pressed)
//   key_down      out  debounced level, 1 = pressed
//   press_pulse   out  1-cycle pulse on committed press
//   release_pulse out  1-cycle pulse on committed release
//   long_pulse    out  1-cycle pulse on long press
module key_debounce_ch
  import key_cond_pkg::*;
#(
  parameter int DB_CYCLES   = 500_000,
  parameter int LONG_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_down,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int            CW      = cnt_width(LONG_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // Two-flop synchroniser. It is preset to 1 (released), so a key that is held
  // through reset is seen as a fresh press once reset lifts.
  logic [1:0] sync;
  logic       s;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], key_n};
  end

  assign s = ~sync[1];

  key_state_t    state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          press_set, release_set;

  // NOTE: every signal is given a default before the case statement. Without
  // the defaults, a path that leaves a signal unassigned would infer a latch.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    press_set   = 1'b0;
    release_set = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_next = IDLE;
        end else if (cnt == DB_LAST) begin
          state_next = PRESSED;
          press_set  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to pressed keeps the long counter, so a held key that
        // glitches open does not restart its long-press timing.
        if (s) begin
          state_next = PRESSED;
        end else if (cnt == DB_LAST) begin
          state_next  = IDLE;
          release_set = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      press_pulse   <= press_set;
      release_pulse <= release_set;
    end
  end

  assign key_down = (state == PRESSED) || (state == RELEASE_WAIT);

`ifdef KEY_LONGPRESS_EN
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] LONG_SAT  = CW'(LONG_CYCLES);

  logic [CW-1:0] lcnt, lcnt_next;
  logic          long_set;

  // The counter is cleared on the cycle press_pulse is issued. It counts up
  // while PRESSED and parks at LONG_CYCLES. The value LONG_CYCLES-1 is passed
  // only once per press, so no separate fired flag is needed.
  always_comb begin
    lcnt_next = lcnt;
    long_set  = 1'b0;
    if (press_set) begin
      lcnt_next = '0;
    end else if (state == PRESSED && s) begin
      if (lcnt == LONG_LAST) long_set = 1'b1;
      if (lcnt != LONG_SAT)  lcnt_next = lcnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lcnt       <= '0;
      long_pulse <= 1'b0;
    end else begin
      lcnt       <= lcnt_next;
      long_pulse <= long_set;
    end
  end
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner
//   Conditions the DE10-Lite push-buttons for the stopwatch core. Each key
//   gets an independent key_debounce_ch channel. Downstream logic uses only
//   the pulses, never the raw KEY inputs.
//   RST is asserted asynchronously. Its deassertion is expected to be
//   synchronous to CLOCK_50, which the board-level reset logic provides.
// Configuration
//   KEY_LONGPRESS_EN : enables long_pulse generation in every channel.
//                      When undefined, long_pulse is tied to 0.
// Ports
//   CLOCK_50       in   system clock, 50 MHz
//   RST            in   asynchronous reset, active-high
//   KEY            in   raw buttons, active-low (0 = pressed)
//   key_down       out  debounced level per key, 1 = pressed
//   press_pulse    out  1-cycle pulse per key on committed press
//   release_pulse  out  1-cycle pulse per key on committed release
//   long_pulse     out  1-cycle pulse per key on long press
module key_conditioner #(
  parameter int NUM_KEYS    = 2,
  parameter int DB_CYCLES   = 500_000,
  parameter int LONG_CYCLES = 50_000_000
) (
  input  logic                CLOCK_50,
  input  logic                RST,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] long_pulse
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DB_CYCLES  (DB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_ch (
      .clk          (CLOCK_50),
      .rst          (RST),
      .key_n        (KEY[i]),
      .key_down     (key_down[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner
//   Directed bench for key_conditioner with DB_CYCLES=4 and LONG_CYCLES=20.
//   Inputs are driven on the falling edge, and outputs are sampled 1 ns after
//   the rising edge. Within each window, "edge j" is the rising edge that
//   samples the value driven just before it. A committed press or release
//   therefore shows its pulse right after edge j0+6, where j0 is the first
//   edge that samples the new level.
//   The observed vector is {key_down, press_pulse, release_pulse, long_pulse}.
module tb_key_conditioner;

  localparam int DB   = 4;
  localparam int LONG = 20;
`ifdef KEY_LONGPRESS_EN
  localparam bit LP = 1'b1;
`else
  localparam bit LP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key;
  logic [1:0] key_down, press_pulse, release_pulse, long_pulse;
  logic [7:0] obs, exp;
  int         vectors     = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  key_conditioner #(
    .NUM_KEYS   (2),
    .DB_CYCLES  (DB),
    .LONG_CYCLES(LONG)
  ) dut (
    .CLOCK_50     (clk),
    .RST          (rst),
    .KEY          (key),
    .key_down     (key_down),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse)
  );

  assign obs = {key_down, press_pulse, release_pulse, long_pulse};

  task automatic test_reset();
    rst = 1'b1;
    key = 2'b11;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      exp = 8'h00;
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL reset_hold j=%0d got=%b want=%b", j, obs, exp);
      end
    end
    @(negedge clk) rst = 1'b0;
    for (int j = 0; j < 50; j++) begin
      @(posedge clk); #1;
      exp = 8'h00;
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL reset_idle j=%0d got=%b want=%b", j, obs, exp);
      end
    end
  endtask

  // Releases the keys in mask, which must currently be committed-down. The
  // other keys are idle.
  task automatic test_release(input logic [1:0] mask, input string name);
    for (int j = 0; j < 9; j++) begin
      @(negedge clk) if (j == 0) key = key | mask;
      @(posedge clk); #1;
      exp = {(j < 6) ? mask : 2'b00, 2'b00, (j == 6) ? mask : 2'b00, 2'b00};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL %s j=%0d got=%b want=%b", name, j, obs, exp);
      end
    end
  endtask

  task automatic test_press_single();
    for (int j = 0; j < 9; j++) begin
      @(negedge clk) if (j == 0) key = 2'b10;
      @(posedge clk); #1;
      exp = {1'b0, (j >= 6), 1'b0, (j == 6), 4'b0000};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL press_single j=%0d got=%b want=%b", j, obs, exp);
      end
    end
    test_release(2'b01, "release_single");
  endtask

  task automatic test_bounce();
    for (int j = 0; j < 26; j++) begin
      // Two edges low, two edges high, three times, then the key stays low.
      // The last edge first samples low at j=12.
      @(negedge clk) key = {1'b1, (j < 12) ? logic'((j / 2) % 2) : 1'b0};
      @(posedge clk); #1;
      exp = {1'b0, (j >= 18), 1'b0, (j == 18), 4'b0000};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL bounce j=%0d got=%b want=%b", j, obs, exp);
      end
    end
    test_release(2'b01, "release_bounce");
  endtask

  task automatic test_long_press();
    // KEY[1] is low for edges 0..39. Press commits at 6, long fires at 26, the
    // release is first sampled at 40 and commits at 46.
    for (int j = 0; j < 56; j++) begin
      @(negedge clk) key = (j < 40) ? 2'b01 : 2'b11;
      @(posedge clk); #1;
      exp = {(j >= 6 && j <= 45), 1'b0, (j == 6), 1'b0,
             (j == 46), 1'b0, (LP && j == 26), 1'b0};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL long_press j=%0d got=%b want=%b", j, obs, exp);
      end
    end
  endtask

  task automatic test_both_keys();
    for (int j = 0; j < 20; j++) begin
      @(negedge clk) key = (j < 10) ? 2'b00 : 2'b11;
      @(posedge clk); #1;
      exp = {(j >= 6 && j <= 15) ? 2'b11 : 2'b00, (j == 6) ? 2'b11 : 2'b00,
             (j == 16) ? 2'b11 : 2'b00, 2'b00};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL both_keys j=%0d got=%b want=%b", j, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    for (int j = 0; j < 7; j++) begin
      @(negedge clk) if (j == 0) key = 2'b10;
      @(posedge clk); #1;
      exp = {1'b0, (j >= 6), 1'b0, (j == 6), 4'b0000};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL pre_reset j=%0d got=%b want=%b", j, obs, exp);
      end
    end
    // Reset lands while press_pulse[0] is still high. Both the pulse and the
    // level must drop without waiting for a clock edge.
    @(negedge clk) rst = 1'b1;
    #1;
    exp = 8'h00;
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL reset_async got=%b want=%b", obs, exp);
    end
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1;
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL reset_mid j=%0d got=%b want=%b", j, obs, exp);
      end
    end
    // KEY[0] remains held. The first edge after deassert samples it low.
    for (int j = 0; j < 12; j++) begin
      @(negedge clk) if (j == 0) rst = 1'b0;
      @(posedge clk); #1;
      exp = {1'b0, (j >= 6), 1'b0, (j == 6), 4'b0000};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL post_reset j=%0d got=%b want=%b", j, obs, exp);
      end
    end
    test_release(2'b01, "release_post_reset");
  endtask

  initial begin
    test_reset();
    test_press_single();
    test_bounce();
    test_long_press();
    test_both_keys();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
